// File: rtl/fft_pkg.sv
// Shared constants, bank-state encoding and index helper for the FFT output reorder slice.
package fft_pkg;

    localparam int unsigned FFT_N     = 16;
    localparam int unsigned FFT_LOG2N = 4;
    localparam int unsigned FFT_WIDTH = 16;

    typedef enum logic [1:0] {
        BankEmpty,
        BankFilling,
        BankFull,
        BankDraining
    } bank_state_e;

    // Reverse the low log2n bits of idx; upper result bits are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned log2n);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < log2n) begin
                r = {r[30:0], idx[i]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One ping-pong bank: flop array with a synchronous write port and a combinational read port.
module fft_reorder_bank
    import fft_pkg::*;
#(
    parameter int unsigned DW    = 2 * FFT_WIDTH,
    parameter int unsigned DEPTH = FFT_N,
    parameter int unsigned AW    = FFT_LOG2N
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Storage needs no reset: bank state gates every read of stale contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_output_reorder.sv
// Bit-reversed to natural-order reorder buffer with two ping-pong banks and valid/ready ports.
// Optional sticky overflow detection is built when FFT_REORDER_OVF_EN is defined.
module fft_output_reorder
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = FFT_WIDTH,
    parameter int unsigned N     = FFT_N,
    parameter int unsigned LOG2N = FFT_LOG2N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] In_Re,
    input  logic [WIDTH-1:0] In_Im,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] Out_Re,
    output logic [WIDTH-1:0] Out_Im,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [LOG2N-1:0] Out_Index,
    output logic             Out_Last,
    output logic             Ovf_Flag
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    bank_state_e          st_q [2];
    bank_state_e          st_d [2];
    logic                 wr_bank_q, rd_bank_q, out_bank_q, init_q;
    logic [LOG2N-1:0]     wr_cnt_q, rd_cnt_q, waddr;
    logic [2*WIDTH-1:0]   rdata0, rdata1, rdata_sel;
    logic                 wr_free, rd_avail, in_fire, load, out_fire;

    // A draining bank whose last sample already sits in the output register may be refilled;
    // this keeps In_Ready high across frame boundaries with an always-ready consumer.
    assign wr_free  = (st_q[wr_bank_q] == BankEmpty) || (st_q[wr_bank_q] == BankFilling) ||
                      ((st_q[wr_bank_q] == BankDraining) && (rd_bank_q != wr_bank_q));
    assign In_Ready = init_q && wr_free;
    assign in_fire  = In_Valid && In_Ready;

    assign rd_avail = (st_q[rd_bank_q] == BankFull) || (st_q[rd_bank_q] == BankDraining);
    assign load     = (!Out_Valid || Out_Ready) && rd_avail;
    assign out_fire = Out_Valid && Out_Ready;

    assign waddr     = LOG2N'(bitrev(32'(wr_cnt_q), LOG2N));
    assign rdata_sel = rd_bank_q ? rdata1 : rdata0;

    fft_reorder_bank #(
        .DW    (2 * WIDTH),
        .DEPTH (N),
        .AW    (LOG2N)
    ) u_bank0 (
        .clk   (clk),
        .we    (in_fire && !wr_bank_q),
        .waddr (waddr),
        .wdata ({In_Re, In_Im}),
        .raddr (rd_cnt_q),
        .rdata (rdata0)
    );

    fft_reorder_bank #(
        .DW    (2 * WIDTH),
        .DEPTH (N),
        .AW    (LOG2N)
    ) u_bank1 (
        .clk   (clk),
        .we    (in_fire && wr_bank_q),
        .waddr (waddr),
        .wdata ({In_Re, In_Im}),
        .raddr (rd_cnt_q),
        .rdata (rdata1)
    );

    // Bank state next-value: release on last acceptance, drain on first load, write wins last.
    always_comb begin
        st_d[0] = st_q[0];
        st_d[1] = st_q[1];
        if (out_fire && Out_Last && (st_q[out_bank_q] == BankDraining)) begin
            st_d[out_bank_q] = BankEmpty;
        end
        if (load && (rd_cnt_q == '0)) begin
            st_d[rd_bank_q] = BankDraining;
        end
        if (in_fire) begin
            st_d[wr_bank_q] = (wr_cnt_q == LAST_IDX) ? BankFull : BankFilling;
        end
    end

    // Bank states, write/read pointers and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q[0]   <= BankEmpty;
            st_q[1]   <= BankEmpty;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            init_q    <= 1'b0;
        end else begin
            init_q  <= 1'b1;
            st_q[0] <= st_d[0];
            st_q[1] <= st_d[1];
            if (in_fire) begin
                wr_cnt_q <= (wr_cnt_q == LAST_IDX) ? '0 : wr_cnt_q + 1'b1;
                if (wr_cnt_q == LAST_IDX) begin
                    wr_bank_q <= ~wr_bank_q;
                end
            end
            if (load) begin
                rd_cnt_q <= (rd_cnt_q == LAST_IDX) ? '0 : rd_cnt_q + 1'b1;
                if (rd_cnt_q == LAST_IDX) begin
                    rd_bank_q <= ~rd_bank_q;
                end
            end
        end
    end

    // Registered output stage; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Out_Re     <= '0;
            Out_Im     <= '0;
            Out_Valid  <= 1'b0;
            Out_Index  <= '0;
            Out_Last   <= 1'b0;
            out_bank_q <= 1'b0;
        end else if (load) begin
            Out_Re     <= rdata_sel[2*WIDTH-1:WIDTH];
            Out_Im     <= rdata_sel[WIDTH-1:0];
            Out_Valid  <= 1'b1;
            Out_Index  <= rd_cnt_q;
            Out_Last   <= (rd_cnt_q == LAST_IDX);
            out_bank_q <= rd_bank_q;
        end else if (out_fire) begin
            Out_Valid <= 1'b0;
        end
    end

`ifdef FFT_REORDER_OVF_EN
    // Sticky flag for samples offered while no bank can take them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Ovf_Flag <= 1'b0;
        end else if (In_Valid && !In_Ready) begin
            Ovf_Flag <= 1'b1;
        end
    end
`else
    assign Ovf_Flag = 1'b0;
`endif

endmodule

// File: tb/tb_fft_output_reorder.sv
// Scoreboard bench for fft_output_reorder: driver pushes expected natural-order frames,
// a negedge monitor pops and compares every accepted output.
`timescale 1ns/1ps
module tb_fft_output_reorder;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

`ifdef FFT_REORDER_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_re = '0, in_im = '0;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] out_re, out_im;
    logic        out_valid, out_ready = 1'b1, out_last, ovf_flag;
    logic [3:0]  out_index;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic inrdy_chk = 1'b0, gap_chk = 1'b0, started = 1'b0;

    // Input position that lands at natural output index k (hand-derived 4-bit reversal).
    int pos_tab[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    logic [15:0] fr_re[16];
    logic [15:0] fr_im[16];

    always #5 clk = ~clk;

    fft_output_reorder dut (
        .clk       (clk),
        .rst       (rst),
        .In_Re     (in_re),
        .In_Im     (in_im),
        .In_Valid  (in_valid),
        .In_Ready  (in_ready),
        .Out_Re    (out_re),
        .Out_Im    (out_im),
        .Out_Valid (out_valid),
        .Out_Ready (out_ready),
        .Out_Index (out_index),
        .Out_Last  (out_last),
        .Ovf_Flag  (ovf_flag)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops, In_Ready continuity and output-gap checks.
    always @(negedge clk) begin
        exp_t got, e;
        if (rst) begin
            if (gap_chk) begin
                if (out_valid) started = 1'b1;
                else if (started && sb.size() > 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_gap: got Out_Valid 0 expected 1 at %0t", $time);
                end
            end
            if (inrdy_chk) begin
                checks++;
                if (!in_ready) begin
                    errors++;
                    $display("FAIL in_ready_const: got 0 expected 1 at %0t", $time);
                end
            end
            if (out_valid && out_ready) begin
                got = '{re: out_re, im: out_im, idx: out_index, last: out_last};
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got re=%h im=%h idx=%0d, expected none",
                             out_re, out_im, out_index);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL out_sample: got re=%h im=%h idx=%0d last=%b expected re=%h im=%h idx=%0d last=%b",
                                 got.re, got.im, got.idx, got.last, e.re, e.im, e.idx, e.last);
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] re, input logic [15:0] im);
        logic acc;
        int   t;
        in_re = re;
        in_im = im;
        in_valid = 1'b1;
        acc = 1'b0;
        t = 0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
            if (!acc && t >= 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got In_Ready 0 for %0d cycles expected 1", t);
                return;
            end
        end
    endtask

    task automatic fill_frame(input logic [15:0] base);
        for (int p = 0; p < 16; p++) begin
            fr_re[p] = base + 16'(p);
            fr_im[p] = -(base + 16'(p));
        end
    endtask

    task automatic send_frame();
        exp_t e;
        for (int p = 0; p < 16; p++) send(fr_re[p], fr_im[p]);
        for (int k = 0; k < 16; k++) begin
            e.re   = fr_re[pos_tab[k]];
            e.im   = fr_im[pos_tab[k]];
            e.idx  = 4'(k);
            e.last = (k == 15);
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [32:0] snap;
        logic        saw_drop;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", {out_re, out_im}, 64'd0);
        chk("rst_out_idx_last", {out_index, out_last}, 64'd0);
        chk("rst_ovf", 64'(ovf_flag), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Single frame: Re = p, Im = -p, with latency check
        fill_frame(16'h0000);
        send_frame();
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_not_yet", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("latency_valid", {out_valid, out_index}, {1'b1, 4'd0});
        wait_drain();

        // Back-to-back 4 frames, always-ready consumer
        inrdy_chk = 1'b1;
        gap_chk   = 1'b1;
        started   = 1'b0;
        for (int f = 0; f < 4; f++) begin
            fill_frame(16'h1000 * 16'(f + 1));
            send_frame();
        end
        inrdy_chk = 1'b0;
        in_valid  = 1'b0;
        wait_drain();
        gap_chk = 1'b0;

        // Backpressure: 40-cycle stall mid-stream
        saw_drop = 1'b0;
        snap = '0;
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    fill_frame(16'h0100 * 16'(f + 1));
                    send_frame();
                end
                in_valid = 1'b0;
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (!in_ready) saw_drop = 1'b1;
                    chk("stall_valid", 64'(out_valid), 64'd1);
                    if (c == 0) snap = {out_re, out_im, out_last};
                    else chk("stall_hold", 64'({out_re, out_im, out_last}), 64'(snap));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        chk("stall_in_ready_drop", 64'(saw_drop), 64'd1);
        wait_drain();

        // Extremes passed bit-exact
        fill_frame(16'h0010);
        fr_re[0]  = 16'h7FFF; fr_im[0]  = 16'h8000;
        fr_re[5]  = 16'h8000; fr_im[5]  = 16'h7FFF;
        fr_re[8]  = 16'h7FFF; fr_im[8]  = 16'h7FFF;
        fr_re[15] = 16'h7FFF; fr_im[15] = 16'h8000;
        send_frame();
        in_valid = 1'b0;
        wait_drain();

        // Overflow: offer samples while both banks are occupied
        out_ready = 1'b0;
        fill_frame(16'h0400);
        send_frame();
        fill_frame(16'h0500);
        send_frame();
        in_valid = 1'b0;
        @(negedge clk);
        chk("both_full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        in_re = 16'hDEAD;
        in_im = 16'hBEEF;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("ovf_set", 64'(ovf_flag), 64'(OVF_EXP));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();
        chk("ovf_sticky", 64'(ovf_flag), 64'(OVF_EXP));

        // Reset asserted at sample 7 of the second frame
        fill_frame(16'h0600);
        send_frame();
        fill_frame(16'h0A00);
        for (int p = 0; p < 7; p++) send(fr_re[p], fr_im[p]);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", {out_re, out_im}, 64'd0);
        chk("midrst_idx_last", {out_index, out_last}, 64'd0);
        chk("midrst_ovf", 64'(ovf_flag), 64'd0);
        in_valid = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_midrst", 64'(in_ready), 64'd1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("no_stale_out", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        fill_frame(16'h0700);
        send_frame();
        in_valid = 1'b0;
        wait_drain();
        chk("sb_empty_end", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
